// File: rtl/uart_cmd_parser.sv
// Byte-stream command decoder: parses cmd/count_lo/count_hi headers, assembles
// little-endian payload words into BRAM write strobes, or requests a data readback.
module uart_cmd_parser #(
  parameter int unsigned DATA_SIZE      = 64,
  parameter int unsigned DATA_ADDRS     = 2,
  parameter int unsigned OP_SIZE        = 8,
  parameter int unsigned OP_ADDRS       = 12,
  parameter int unsigned WEIGHT_SIZE    = 96,
  parameter int unsigned WEIGHT_ADDRS   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [7:0]                      rx_byte_in,
  input  logic                            rx_valid_in,
  input  logic                            rd_done_in,
  output logic                            data_we_out,
  output logic [$clog2(DATA_ADDRS)-1:0]   data_addr_out,
  output logic [DATA_SIZE-1:0]            data_wdata_out,
  output logic                            op_we_out,
  output logic [$clog2(OP_ADDRS)-1:0]     op_addr_out,
  output logic [OP_SIZE-1:0]              op_wdata_out,
  output logic                            wt_we_out,
  output logic [$clog2(WEIGHT_ADDRS)-1:0] wt_addr_out,
  output logic [WEIGHT_SIZE-1:0]          wt_wdata_out,
  output logic                            rd_start_out,
  output logic [15:0]                     rd_count_out,
  output logic                            busy_out,
  output logic                            err_out
);

  localparam int unsigned DATA_AW   = $clog2(DATA_ADDRS);
  localparam int unsigned OP_AW     = $clog2(OP_ADDRS);
  localparam int unsigned WT_AW     = $clog2(WEIGHT_ADDRS);
  localparam int unsigned MAX_AW_DO = (DATA_AW > OP_AW) ? DATA_AW : OP_AW;
  localparam int unsigned MAX_AW    = (MAX_AW_DO > WT_AW) ? MAX_AW_DO : WT_AW;
  localparam int unsigned MAX_SZ_DO = (DATA_SIZE > OP_SIZE) ? DATA_SIZE : OP_SIZE;
  localparam int unsigned MAX_SIZE  = (MAX_SZ_DO > WEIGHT_SIZE) ? MAX_SZ_DO : WEIGHT_SIZE;
  localparam int unsigned MAX_BYTES = MAX_SIZE / 8;
  localparam int unsigned BCNT_W    = $clog2(MAX_BYTES + 1);
  localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_WR_DATA = 8'h00;
  localparam logic [7:0] CMD_WR_WT   = 8'h01;
  localparam logic [7:0] CMD_WR_OP   = 8'h02;
  localparam logic [7:0] CMD_RD_DATA = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_HDR2,
    S_PAYLOAD,
    S_RD_WAIT
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [7:0]          r_cmd;
  logic [15:0]         r_count;
  logic [15:0]         r_word_cnt;
  logic [BCNT_W-1:0]   r_byte_cnt;
  logic [MAX_AW-1:0]   r_addr;
  logic [MAX_SIZE-1:0] r_buf;
  logic [TMO_W-1:0]    r_tmo;

  logic [MAX_SIZE-1:0] w_word;
  logic [BCNT_W-1:0]   w_bpw_m1;
  logic [MAX_AW-1:0]   w_depth_m1;
  logic                w_timed;
  logic                w_tmo_expire;
  logic                w_err;
  logic                w_word_done;
  logic                w_rd_start;

  assign w_timed      = (r_state == S_HDR1) || (r_state == S_HDR2) || (r_state == S_PAYLOAD);
  assign w_tmo_expire = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  // Word geometry of the BRAM selected by the latched command
  always_comb begin
    w_bpw_m1   = BCNT_W'(OP_SIZE / 8 - 1);
    w_depth_m1 = MAX_AW'(OP_ADDRS - 1);
    case (r_cmd)
      CMD_WR_DATA: begin
        w_bpw_m1   = BCNT_W'(DATA_SIZE / 8 - 1);
        w_depth_m1 = MAX_AW'(DATA_ADDRS - 1);
      end
      CMD_WR_WT: begin
        w_bpw_m1   = BCNT_W'(WEIGHT_SIZE / 8 - 1);
        w_depth_m1 = MAX_AW'(WEIGHT_ADDRS - 1);
      end
      default: ;
    endcase
  end

  // Current word with the incoming byte merged at its little-endian position
  always_comb begin
    w_word = r_buf;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (BCNT_W'(i) == r_byte_cnt) w_word[8*i +: 8] = rx_byte_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_err        = 1'b0;
    w_word_done  = 1'b0;
    w_rd_start   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_valid_in) w_next_state = S_HDR1;
      end
      S_HDR1: begin
        if (rx_valid_in) begin
          w_next_state = S_HDR2;
        end else if (w_tmo_expire) begin
          w_err        = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_HDR2: begin
        if (rx_valid_in) begin
          case (r_cmd)
            CMD_WR_DATA, CMD_WR_WT, CMD_WR_OP: w_next_state = S_PAYLOAD;
            CMD_RD_DATA: begin
              w_rd_start   = 1'b1;
              w_next_state = S_RD_WAIT;
            end
            default: begin
              w_err        = 1'b1;
              w_next_state = S_IDLE;
            end
          endcase
        end else if (w_tmo_expire) begin
          w_err        = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (rx_valid_in) begin
          if (r_byte_cnt == w_bpw_m1) begin
            w_word_done = 1'b1;
            if (r_word_cnt == r_count) w_next_state = S_IDLE;
          end
        end else if (w_tmo_expire) begin
          w_err        = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (rd_done_in) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Header latching, payload assembly, write/readback strobes
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cmd          <= '0;
      r_count        <= '0;
      r_word_cnt     <= '0;
      r_byte_cnt     <= '0;
      r_addr         <= '0;
      r_buf          <= '0;
      r_tmo          <= '0;
      data_we_out    <= 1'b0;
      data_addr_out  <= '0;
      data_wdata_out <= '0;
      op_we_out      <= 1'b0;
      op_addr_out    <= '0;
      op_wdata_out   <= '0;
      wt_we_out      <= 1'b0;
      wt_addr_out    <= '0;
      wt_wdata_out   <= '0;
      rd_start_out   <= 1'b0;
      rd_count_out   <= '0;
      busy_out       <= 1'b0;
      err_out        <= 1'b0;
    end else begin
      data_we_out  <= 1'b0;
      op_we_out    <= 1'b0;
      wt_we_out    <= 1'b0;
      rd_start_out <= w_rd_start;
      err_out      <= w_err;
      busy_out     <= (w_next_state != S_IDLE);

      if (rx_valid_in || !w_timed) r_tmo <= '0;
      else                         r_tmo <= r_tmo + TMO_W'(1);

      case (r_state)
        S_IDLE: if (rx_valid_in) r_cmd <= rx_byte_in;
        S_HDR1: if (rx_valid_in) r_count[7:0] <= rx_byte_in;
        S_HDR2: begin
          if (rx_valid_in) begin
            r_count[15:8] <= rx_byte_in;
            r_word_cnt    <= '0;
            r_byte_cnt    <= '0;
            r_addr        <= '0;
            if (w_rd_start) rd_count_out <= {rx_byte_in, r_count[7:0]};
          end
        end
        S_PAYLOAD: begin
          if (rx_valid_in) begin
            r_buf <= w_word;
            if (w_word_done) begin
              r_byte_cnt <= '0;
              r_word_cnt <= r_word_cnt + 16'd1;
              r_addr     <= (r_addr == w_depth_m1) ? '0 : r_addr + MAX_AW'(1);
              case (r_cmd)
                CMD_WR_DATA: begin
                  data_we_out    <= 1'b1;
                  data_addr_out  <= DATA_AW'(r_addr);
                  data_wdata_out <= w_word[DATA_SIZE-1:0];
                end
                CMD_WR_WT: begin
                  wt_we_out    <= 1'b1;
                  wt_addr_out  <= WT_AW'(r_addr);
                  wt_wdata_out <= w_word[WEIGHT_SIZE-1:0];
                end
                default: begin
                  op_we_out    <= 1'b1;
                  op_addr_out  <= OP_AW'(r_addr);
                  op_wdata_out <= w_word[OP_SIZE-1:0];
                end
              endcase
            end else begin
              r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
            end
          end
        end
        S_RD_WAIT: if (rd_done_in) rd_count_out <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus pushes expected strobes from a
// byte-level reference model, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_cmd_parser;

  localparam int unsigned TMO = 300;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   rx_byte = 8'h00;
  logic         rx_valid = 1'b0;
  logic         rd_done = 1'b0;
  logic         data_we, op_we, wt_we, rd_start, busy, err;
  logic [0:0]   data_addr, wt_addr;
  logic [3:0]   op_addr;
  logic [63:0]  data_wdata;
  logic [7:0]   op_wdata;
  logic [95:0]  wt_wdata;
  logic [15:0]  rd_count;

  int checks = 0;
  int errors = 0;

  typedef enum int {K_DATA, K_OP, K_WT, K_RD, K_ERR} kind_t;
  typedef struct {
    kind_t       kind;
    int          addr;
    logic [95:0] data;
  } ev_t;
  typedef logic [7:0] byte_q_t[$];

  ev_t exp_q[$];

  uart_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_in(clk), .rst_in(rst_n), .rx_byte_in(rx_byte), .rx_valid_in(rx_valid),
    .rd_done_in(rd_done),
    .data_we_out(data_we), .data_addr_out(data_addr), .data_wdata_out(data_wdata),
    .op_we_out(op_we), .op_addr_out(op_addr), .op_wdata_out(op_wdata),
    .wt_we_out(wt_we), .wt_addr_out(wt_addr), .wt_wdata_out(wt_wdata),
    .rd_start_out(rd_start), .rd_count_out(rd_count), .busy_out(busy), .err_out(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push_ev(input kind_t k, input int a, input logic [95:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input kind_t k, input int a, input logic [95:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got addr=%0d data=%h, required no strobe", k.name(), a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data !== d) begin
        errors++;
        $display("FAIL event_%s: got kind=%s addr=%0d data=%h, required kind=%s addr=%0d data=%h",
                 e.kind.name(), k.name(), a, d, e.kind.name(), e.addr, e.data);
      end
    end
  endtask

  // Monitor: every strobe the DUT presents must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_we)  check_evt(K_DATA, int'(data_addr), 96'(data_wdata));
      if (op_we)    check_evt(K_OP, int'(op_addr), 96'(op_wdata));
      if (wt_we)    check_evt(K_WT, int'(wt_addr), wt_wdata);
      if (rd_start) check_evt(K_RD, 0, 96'(rd_count));
      if (err)      check_evt(K_ERR, 0, 96'(0));
    end
  end

  // Reference model: N+1 words, little-endian bytes, address = word index mod depth
  task automatic model_wr(input logic [7:0] cmd, input int n, input byte_q_t pl);
    int bpw, depth;
    kind_t k;
    logic [95:0] w;
    case (cmd)
      8'h00:   begin bpw = 8;  depth = 2;  k = K_DATA; end
      8'h01:   begin bpw = 12; depth = 2;  k = K_WT;   end
      default: begin bpw = 1;  depth = 12; k = K_OP;   end
    endcase
    for (int i = 0; i <= n; i++) begin
      w = '0;
      for (int j = 0; j < bpw; j++) w = w | (96'(pl[i*bpw + j]) << (8*j));
      push_ev(k, i % depth, w);
    end
  endtask

  task automatic send_one(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_bytes(input byte_q_t bq, input int max_gap);
    foreach (bq[i]) send_one(bq[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_drain_left"}, 96'(exp_q.size()), 96'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_wr(input logic [7:0] cmd, input int n, input int max_gap);
    byte_q_t pl, bq;
    int bpw;
    bpw = (cmd == 8'h00) ? 8 : (cmd == 8'h01) ? 12 : 1;
    for (int i = 0; i < (n + 1) * bpw; i++) pl.push_back(8'($urandom));
    model_wr(cmd, n, pl);
    bq.push_back(cmd);
    bq.push_back(8'(n));
    bq.push_back(8'(n >> 8));
    foreach (pl[i]) bq.push_back(pl[i]);
    send_bytes(bq, max_gap);
    drain("wr");
    chk("wr_busy_after", 96'(busy), 96'(0));
  endtask

  task automatic run_rd(input int n, input int max_gap, input bit same_cycle_done);
    byte_q_t bq, extra;
    push_ev(K_RD, 0, 96'(n));
    bq.push_back(8'h04);
    bq.push_back(8'(n));
    bq.push_back(8'(n >> 8));
    send_bytes(bq, max_gap);
    if (!same_cycle_done) begin
      for (int i = 0; i < 3; i++) extra.push_back(8'($urandom));
      send_bytes(extra, 1);
      repeat (2) @(negedge clk);
      chk("rd_busy_held", 96'(busy), 96'(1));
      chk("rd_count_held", 96'(rd_count), 96'(n));
    end
    rd_done = 1'b1;
    @(negedge clk);
    rd_done = 1'b0;
    chk("rd_idle_after_done", 96'(busy), 96'(0));
    drain("rd");
  endtask

  task automatic run_bad(input logic [7:0] cmd);
    byte_q_t bq;
    push_ev(K_ERR, 0, 96'(0));
    bq.push_back(cmd);
    bq.push_back(8'($urandom));
    bq.push_back(8'($urandom));
    send_bytes(bq, 1);
    chk("bad_cmd_err_pulse", 96'(err), 96'(1));
    drain("bad");
    chk("bad_cmd_busy", 96'(busy), 96'(0));
  endtask

  function automatic logic any_out();
    return |{data_we, data_addr, data_wdata, op_we, op_addr, op_wdata, wt_we, wt_addr,
             wt_wdata, rd_start, rd_count, busy, err};
  endfunction

  initial begin
    byte_q_t bq;
    int cyc;
    bit seen;
    int r;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 96'(any_out()), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // T1 op write
    push_ev(K_OP, 0, 96'h03);
    bq = '{8'h02, 8'h00, 8'h00, 8'h03};
    send_bytes(bq, 0);
    chk("t1_op_we_one_cycle_after", 96'(op_we), 96'(1));
    @(negedge clk);
    chk("t1_op_we_single", 96'(op_we), 96'(0));
    chk("t1_op_wdata_hold", 96'(op_wdata), 96'h03);
    drain("t1");
    chk("t1_busy", 96'(busy), 96'(0));

    // T2 data write, two words
    push_ev(K_DATA, 0, 96'h3D3C3B3A39383736);
    push_ev(K_DATA, 1, 96'h4544434241403F3E);
    bq = '{8'h00, 8'h01, 8'h00};
    for (int i = 0; i < 16; i++) bq.push_back(8'(8'h36 + i));
    send_bytes(bq, 2);
    drain("t2");

    // T3 op wrap with back-to-back bytes
    run_wr(8'h02, 12, 0);

    // T4 readback, delayed and same-cycle rd_done
    run_rd(5, 0, 1'b0);
    run_rd(9, 1, 1'b1);

    // T5 bad command, then timeout with a partial weight word
    run_bad(8'h07);
    push_ev(K_ERR, 0, 96'(0));
    bq = '{8'h01, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_bytes(bq, 0);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < int'(TMO) + 20) begin
      @(negedge clk);
      cyc++;
      if (err) seen = 1'b1;
    end
    chk("t5_timeout_latency", 96'(cyc), 96'(TMO));
    drain("t5");
    chk("t5_busy", 96'(busy), 96'(0));

    // Byte arriving on the cycle the timeout would expire is accepted
    push_ev(K_OP, 0, 96'h5A);
    send_one(8'h02, 0);
    send_one(8'h00, int'(TMO) - 1);
    send_one(8'h00, 0);
    send_one(8'h5A, 0);
    rx_valid = 1'b0;
    drain("tmo_race");

    // T6 asynchronous reset mid-payload, then a clean packet
    bq = '{8'h00, 8'h01, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_bytes(bq, 0);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_reset_outputs", 96'(any_out()), 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_wr(8'h00, 1, 1);

    // Randomized mix of commands
    for (int it = 0; it < 25; it++) begin
      r = int'($urandom_range(9, 0));
      if (r <= 2)      run_wr(8'h00, int'($urandom_range(4, 0)), int'($urandom_range(2, 0)));
      else if (r <= 4) run_wr(8'h01, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)));
      else if (r <= 7) run_wr(8'h02, int'($urandom_range(27, 0)), int'($urandom_range(2, 0)));
      else if (r == 8) run_rd(int'($urandom_range(65535, 0)), 1, 1'($urandom_range(1, 0)));
      else             run_bad(($urandom_range(1, 0) == 1) ? 8'h03 : 8'($urandom_range(255, 5)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
